// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-master video memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_DONE = 2'd2
  } arb_state_e;

  localparam logic P_VGA  = 1'b0;
  localparam logic P_HOST = 1'b1;

  localparam logic [15:0] TIMEOUT_DATA = 16'hDEAD;

endpackage

// File: rtl/mem_arb_watchdog.sv
// BUSY-cycle counter for the arbiter; flags expiry after TIMEOUT_CYCLES cycles
// without a memory acknowledge. Used only in MEM_ARB_TIMEOUT_EN builds.
module mem_arb_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic i_clk,
  input  logic i_reset_n,
  input  logic i_busy,
  output logic expired_c
);

  localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] count_q;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      count_q <= '0;
    end else if (!i_busy) begin
      count_q <= '0;
    end else if (!expired_c) begin
      count_q <= count_q + CW'(1);
    end
  end

  assign expired_c = i_busy && (count_q == CW'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_arbiter.sv
// Fixed-priority arbiter sharing the single-port video/text memory between the
// VGA fetch engine (port 0) and the host path (port 1). Optional memory-ack
// timeout is enabled by defining MEM_ARB_TIMEOUT_EN.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned AW             = 13,
  parameter int unsigned DW             = 16,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic          i_clk,
  input  logic          i_reset_n,
  input  logic [AW-1:0] i_p0_addr,
  input  logic          i_p0_cs,
  output logic [DW-1:0] o_p0_dat,
  output logic          o_p0_ack,
  input  logic [AW-1:0] i_p1_addr,
  input  logic [DW-1:0] i_p1_dat,
  input  logic          i_p1_we,
  input  logic          i_p1_cs,
  output logic [DW-1:0] o_p1_dat,
  output logic          o_p1_ack,
  output logic [AW-1:0] o_mem_addr,
  output logic [DW-1:0] o_mem_dat,
  output logic          o_mem_we,
  output logic          o_mem_cs,
  input  logic [DW-1:0] i_mem_dat,
  input  logic          i_mem_ack,
  output logic          o_p1_err
);

  arb_state_e    state_q, state_d;
  logic          grant_q, grant_d;
  logic [AW-1:0] mem_addr_d;
  logic [DW-1:0] mem_dat_d, p0_dat_d, p1_dat_d, fill_dat;
  logic          mem_we_d, mem_cs_d, p0_ack_d, p1_ack_d, p1_err_d;
  logic          timeout_c;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .i_clk    (i_clk),
    .i_reset_n(i_reset_n),
    .i_busy   (state_q == ARB_BUSY),
    .expired_c(timeout_c)
  );
`else
  // Without the watchdog the timeout depth has no effect.
  logic [31:0] unused_timeout;
  assign unused_timeout = 32'(TIMEOUT_CYCLES);
  assign timeout_c      = 1'b0;
`endif

  // Next-state and next-output decode; every output is registered below.
  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    mem_addr_d = o_mem_addr;
    mem_dat_d  = o_mem_dat;
    mem_we_d   = o_mem_we;
    mem_cs_d   = o_mem_cs;
    p0_dat_d   = o_p0_dat;
    p1_dat_d   = o_p1_dat;
    p0_ack_d   = 1'b0;
    p1_ack_d   = 1'b0;
    p1_err_d   = 1'b0;
    fill_dat   = i_mem_ack ? i_mem_dat : DW'(TIMEOUT_DATA);

    case (state_q)
      ARB_IDLE: begin
        if (i_p0_cs) begin
          grant_d    = P_VGA;
          mem_addr_d = i_p0_addr;
          mem_dat_d  = '0;
          mem_we_d   = 1'b0;
          mem_cs_d   = 1'b1;
          state_d    = ARB_BUSY;
        end else if (i_p1_cs) begin
          grant_d    = P_HOST;
          mem_addr_d = i_p1_addr;
          mem_dat_d  = i_p1_dat;
          mem_we_d   = i_p1_we;
          mem_cs_d   = 1'b1;
          state_d    = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        // A real ack takes precedence over an expiry landing on the same edge.
        if (i_mem_ack || timeout_c) begin
          mem_cs_d = 1'b0;
          mem_we_d = 1'b0;
          if (grant_q == P_HOST) begin
            p1_dat_d = fill_dat;
            p1_ack_d = 1'b1;
            p1_err_d = !i_mem_ack;
          end else begin
            p0_dat_d = fill_dat;
            p0_ack_d = 1'b1;
          end
          state_d = ARB_DONE;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q    <= ARB_IDLE;
      grant_q    <= P_VGA;
      o_mem_addr <= '0;
      o_mem_dat  <= '0;
      o_mem_we   <= 1'b0;
      o_mem_cs   <= 1'b0;
      o_p0_dat   <= '0;
      o_p1_dat   <= '0;
      o_p0_ack   <= 1'b0;
      o_p1_ack   <= 1'b0;
      o_p1_err   <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      o_mem_addr <= mem_addr_d;
      o_mem_dat  <= mem_dat_d;
      o_mem_we   <= mem_we_d;
      o_mem_cs   <= mem_cs_d;
      o_p0_dat   <= p0_dat_d;
      o_p1_dat   <= p1_dat_d;
      o_p0_ack   <= p0_ack_d;
      o_p1_ack   <= p1_ack_d;
      o_p1_err   <= p1_err_d;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: one-cycle-latency memory model, scoreboard of expected acks.
module tb_mem_arbiter;

  localparam int unsigned TO = 15;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [12:0] p0_addr = '0, p1_addr = '0;
  logic [15:0] p1_dat = '0;
  logic        p0_cs = 1'b0, p1_cs = 1'b0, p1_we = 1'b0;
  logic [15:0] o_p0_dat, o_p1_dat, o_mem_dat;
  logic        o_p0_ack, o_p1_ack, o_mem_we, o_mem_cs, o_p1_err;
  logic [12:0] o_mem_addr;
  logic [15:0] mem_rdat = '0;
  logic        mem_ack = 1'b0;
  logic        mem_ack_en = 1'b1;
  logic        mem_init_done = 1'b0;
  logic [15:0] mem [0:8191];

  typedef struct {
    logic        port;
    logic [15:0] dat;
    logic        err;
  } exp_t;
  exp_t exp_q[$];

  int chk_cnt = 0, pass_cnt = 0;
  int cyc = 0, p0_ack_cyc = 0, p1_ack_cyc = 0, p0_ack_n = 0, p1_ack_n = 0;

  mem_arbiter #(.AW(13), .DW(16), .TIMEOUT_CYCLES(TO)) dut (
    .i_clk(clk), .i_reset_n(rst_n),
    .i_p0_addr(p0_addr), .i_p0_cs(p0_cs), .o_p0_dat(o_p0_dat), .o_p0_ack(o_p0_ack),
    .i_p1_addr(p1_addr), .i_p1_dat(p1_dat), .i_p1_we(p1_we), .i_p1_cs(p1_cs),
    .o_p1_dat(o_p1_dat), .o_p1_ack(o_p1_ack),
    .o_mem_addr(o_mem_addr), .o_mem_dat(o_mem_dat), .o_mem_we(o_mem_we), .o_mem_cs(o_mem_cs),
    .i_mem_dat(mem_rdat), .i_mem_ack(mem_ack), .o_p1_err(o_p1_err)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] pat(input int i);
    return 16'((i * 257) ^ 32'h0000A5C3);
  endfunction

  // Memory model: one-cycle ack pulse; writes echo the write data as read data.
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < 8192; i++) mem[i] <= pat(i);
      mem_init_done <= 1'b1;
    end else if (mem_ack_en && o_mem_cs && !mem_ack) begin
      mem_ack <= 1'b1;
      if (o_mem_we) begin
        mem[o_mem_addr] <= o_mem_dat;
        mem_rdat        <= o_mem_dat;
      end else begin
        mem_rdat <= mem[o_mem_addr];
      end
    end else begin
      mem_ack <= 1'b0;
    end
  end

  // Scoreboard: every ack pops the oldest expected completion.
  always @(negedge clk) begin
    if (o_p0_ack || o_p1_ack) begin
      exp_t e;
      chk_cnt++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_ack got p0_ack=%0b p1_ack=%0b exp none", o_p0_ack, o_p1_ack);
      end else begin
        e = exp_q.pop_front();
        if (o_p1_ack !== e.port || (o_p0_ack && o_p1_ack))
          $display("FAIL sb_port got p0_ack=%0b p1_ack=%0b exp port=%0d", o_p0_ack, o_p1_ack, e.port);
        else pass_cnt++;
        chk_cnt++;
        if ((e.port ? o_p1_dat : o_p0_dat) !== e.dat)
          $display("FAIL sb_dat got=%h exp=%h", e.port ? o_p1_dat : o_p0_dat, e.dat);
        else pass_cnt++;
        chk_cnt++;
        if (o_p1_err !== e.err) $display("FAIL sb_err got=%b exp=%b", o_p1_err, e.err);
        else pass_cnt++;
        chk_cnt++;
        if (o_mem_cs !== 1'b0) $display("FAIL sb_cs_in_done got=%b exp=0", o_mem_cs);
        else pass_cnt++;
      end
    end
  end

  // One cycle of requester behaviour: cs drops once its ack is observed.
  task automatic step();
    @(negedge clk);
    cyc++;
    if (o_p0_ack) begin p0_cs = 1'b0; p0_ack_cyc = cyc; p0_ack_n++; end
    if (o_p1_ack) begin p1_cs = 1'b0; p1_ack_cyc = cyc; p1_ack_n++; end
  endtask

  task automatic wait_idle(input int limit, output bit expired);
    int n = 0;
    expired = 1'b0;
    while ((p0_cs || p1_cs) && n < limit) begin step(); n++; end
    if (p0_cs || p1_cs) expired = 1'b1;
    else step();
  endtask

  task automatic req_p0(input logic [12:0] a, input logic [15:0] exp_dat);
    p0_addr = a; p0_cs = 1'b1;
    exp_q.push_back('{port: 1'b0, dat: exp_dat, err: 1'b0});
  endtask

  task automatic req_p1(input logic [12:0] a, input logic [15:0] d, input logic we,
                        input logic [15:0] exp_dat, input logic exp_err);
    p1_addr = a; p1_dat = d; p1_we = we; p1_cs = 1'b1;
    exp_q.push_back('{port: 1'b1, dat: exp_dat, err: exp_err});
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    chk_cnt++;
    if ({o_mem_cs, o_mem_we, o_p0_ack, o_p1_ack, o_p1_err} !== 5'b0)
      $display("FAIL reset_ctrl got=%b exp=00000", {o_mem_cs, o_mem_we, o_p0_ack, o_p1_ack, o_p1_err});
    else pass_cnt++;
    chk_cnt++;
    if ({o_mem_addr, o_mem_dat, o_p0_dat, o_p1_dat} !== 61'b0)
      $display("FAIL reset_data got=%h/%h/%h/%h exp=0", o_mem_addr, o_mem_dat, o_p0_dat, o_p1_dat);
    else pass_cnt++;
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_write_read();
    int k;
    bit to;
    k = cyc;
    req_p1(13'h0100, 16'h1234, 1'b1, 16'h1234, 1'b0);
    step();
    chk_cnt++;
    if ({o_mem_cs, o_mem_we, o_mem_addr, o_mem_dat} !== {1'b1, 1'b1, 13'h0100, 16'h1234})
      $display("FAIL wr_busy got cs=%b we=%b a=%h d=%h exp 1 1 0100 1234", o_mem_cs, o_mem_we, o_mem_addr, o_mem_dat);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (o_mem_we !== 1'b1) $display("FAIL wr_we_hold got=%b exp=1", o_mem_we);
    else pass_cnt++;
    step();
    chk_cnt++;
    if (p1_ack_cyc - k !== 3) $display("FAIL wr_latency got=%0d exp=3", p1_ack_cyc - k);
    else pass_cnt++;
    step();
    chk_cnt++;
    if ({o_p1_ack, o_mem_we} !== 2'b00) $display("FAIL wr_single_ack got ack=%b we=%b exp 0 0", o_p1_ack, o_mem_we);
    else pass_cnt++;
    k = cyc;
    req_p1(13'h0100, 16'h0000, 1'b0, 16'h1234, 1'b0);
    wait_idle(20, to);
    chk_cnt++;
    if (to !== 1'b0 || p1_ack_cyc - k !== 3)
      $display("FAIL rd_back got timeout=%b latency=%0d exp 0 3", to, p1_ack_cyc - k);
    else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    bit to;
    req_p0(13'h0010, pat(16'h0010));
    req_p1(13'h0020, 16'h0000, 1'b0, pat(16'h0020), 1'b0);
    wait_idle(30, to);
    chk_cnt++;
    if (to !== 1'b0 || p1_ack_cyc - p0_ack_cyc !== 4)
      $display("FAIL simul_spacing got timeout=%b gap=%0d exp 0 4", to, p1_ack_cyc - p0_ack_cyc);
    else pass_cnt++;
  endtask

  task automatic test_no_preempt();
    bit to;
    req_p1(13'h0400, 16'hBEEF, 1'b1, 16'hBEEF, 1'b0);
    step();
    req_p0(13'h0005, pat(5));
    step();
    chk_cnt++;
    if ({o_mem_cs, o_mem_addr, o_mem_we} !== {1'b1, 13'h0400, 1'b1})
      $display("FAIL nopre_hold got cs=%b a=%h we=%b exp 1 0400 1", o_mem_cs, o_mem_addr, o_mem_we);
    else pass_cnt++;
    wait_idle(30, to);
    chk_cnt++;
    if (to !== 1'b0 || p0_ack_cyc - p1_ack_cyc !== 4)
      $display("FAIL nopre_order got timeout=%b gap=%0d exp 0 4", to, p0_ack_cyc - p1_ack_cyc);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    int k;
    bit to;
    req_p1(13'h0600, 16'h0000, 1'b0, pat(16'h0600), 1'b0);
    step();
    #2 rst_n = 1'b0;
    #1;
    chk_cnt++;
    if ({o_mem_cs, o_mem_we, o_p0_ack, o_p1_ack} !== 4'b0 || o_mem_addr !== 13'h0)
      $display("FAIL rst_async got cs=%b we=%b acks=%b%b a=%h exp all 0", o_mem_cs, o_mem_we, o_p0_ack, o_p1_ack, o_mem_addr);
    else pass_cnt++;
    p1_cs = 1'b0;
    exp_q.delete();
    step();
    rst_n = 1'b1;
    step();
    k = cyc;
    req_p1(13'h0601, 16'h0000, 1'b0, pat(16'h0601), 1'b0);
    wait_idle(20, to);
    chk_cnt++;
    if (to !== 1'b0 || p1_ack_cyc - k !== 3)
      $display("FAIL rst_recover got timeout=%b latency=%0d exp 0 3", to, p1_ack_cyc - k);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    int k, n0;
    bit to;
    mem_ack_en = 1'b0;
    k = cyc;
    n0 = p1_ack_n;
`ifdef MEM_ARB_TIMEOUT_EN
    req_p1(13'h0700, 16'h0000, 1'b0, 16'hDEAD, 1'b1);
    wait_idle(40, to);
    chk_cnt++;
    if (to !== 1'b0 || p1_ack_cyc - k !== int'(TO) + 1)
      $display("FAIL timeout_latency got timeout=%b latency=%0d exp 0 %0d", to, p1_ack_cyc - k, TO + 1);
    else pass_cnt++;
    mem_ack_en = 1'b1;
`else
    req_p1(13'h0700, 16'h0000, 1'b0, pat(16'h0700), 1'b0);
    repeat (100) step();
    chk_cnt++;
    if (o_mem_cs !== 1'b1 || p1_ack_n !== n0)
      $display("FAIL no_timeout_busy got cs=%b acks=%0d exp 1 %0d", o_mem_cs, p1_ack_n, n0);
    else pass_cnt++;
    mem_ack_en = 1'b1;
    wait_idle(20, to);
    chk_cnt++;
    if (to !== 1'b0 || p1_ack_n !== n0 + 1)
      $display("FAIL no_timeout_release got timeout=%b acks=%0d exp 0 %0d", to, p1_ack_n, n0 + 1);
    else pass_cnt++;
`endif
  endtask

  task automatic test_back_to_back();
    int n0;
    bit to;
    n0 = p0_ack_n;
    for (int i = 0; i < 80; i++) begin
      req_p0(13'(i), pat(i));
      wait_idle(20, to);
      chk_cnt++;
      if (to !== 1'b0 || o_p0_ack !== 1'b0)
        $display("FAIL b2b_pulse idx=%0d got timeout=%b ack=%b exp 0 0", i, to, o_p0_ack);
      else pass_cnt++;
    end
    chk_cnt++;
    if (p0_ack_n - n0 !== 80) $display("FAIL b2b_count got=%0d exp=80", p0_ack_n - n0);
    else pass_cnt++;
    chk_cnt++;
    if (exp_q.size() !== 0) $display("FAIL sb_leftover got=%0d exp=0", exp_q.size());
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_simultaneous();
    test_no_preempt();
    test_reset_mid_busy();
    test_timeout();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got cycle=%0d exp completion", cyc);
    $fatal(1, "bench did not complete");
  end

endmodule
